// File: rtl/dmem_ws.sv
// Wait-state data memory with request/ready handshake and saturating access counter.
// Optional sticky pass detector on DONE is built only when DMEM_PASS_DET_EN is defined.
module dmem_ws #(
  parameter int DW         = 16,
  parameter int AW         = 7,
  parameter int WAIT       = 0,
  parameter int CW         = 16,
  parameter int PASS_ADDR  = 0,
  parameter int PASS_VALUE = 4
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          REQ,
  input  logic          RW,
  input  logic [AW-1:0] DA,
  inout  wire  [DW-1:0] DD,
  output logic          RDY,
  output logic [CW-1:0] ACNT,
  output logic          DONE
);

  // state  | meaning
  // IDLE   | waiting for REQ; request fields latched on acceptance
  // BUSY   | counting down wait states, access committed when counter is 0
  // RESP   | RDY pulse; read data driven on DD
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]    LP_WAIT = 4'(WAIT);
  localparam logic [CW-1:0] LP_AMAX = {CW{1'b1}};

  state_t        r_state;
  state_t        w_nstate;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_rw;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [2**AW];
  logic          w_commit;
  logic          w_dd_oe;

  assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (REQ) w_nstate = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_nstate = S_RESP;
      S_RESP:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    RDY     = 1'b0;
    w_dd_oe = 1'b0;
    if (r_state == S_RESP) begin
      RDY     = 1'b1;
      w_dd_oe = r_rw;
    end
  end

  assign DD = w_dd_oe ? r_rdata : {DW{1'bz}};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      ACNT    <= '0;
    end else begin
      if (r_state == S_IDLE && REQ) begin
        r_addr  <= DA;
        r_rw    <= RW;
        r_wdata <= DD;
        r_cnt   <= LP_WAIT;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && r_rw) r_rdata <= r_mem[r_addr];
      // counter advances on the commit edge, i.e. on entry to RESP
      if (w_commit && ACNT != LP_AMAX) ACNT <= ACNT + 1'b1;
    end
  end

  // storage is deliberately not reset; reset forces IDLE so no commit can occur
  always_ff @(posedge CK) begin
    if (w_commit && !r_rw) r_mem[r_addr] <= r_wdata;
  end

`ifdef DMEM_PASS_DET_EN
  localparam logic [AW-1:0] LP_PASS_ADDR  = AW'(PASS_ADDR);
  localparam logic [DW-1:0] LP_PASS_VALUE = DW'(PASS_VALUE);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) DONE <= 1'b0;
    else if (w_commit && !r_rw && r_addr == LP_PASS_ADDR && r_wdata == LP_PASS_VALUE)
      DONE <= 1'b1;
  end
`else
  assign DONE = 1'b0;
`endif

endmodule
